// File: rtl/ex_mem_pipe_reg.sv
// EX->M pipeline register: valid/ready handshake, flush, forwarding tap, saturating stall counter.
// Optional skid entry (registered o_ready_EX) enabled by `define EX_M_SKID_EN.
module ex_mem_pipe_reg #(
  parameter int DATA_W     = 128,
  parameter int RD_W       = 5,
  parameter int CTRL_W     = 6,
  parameter int RDWREN_BIT = 0,
  parameter int CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid_EX,
  output logic              o_ready_EX,
  input  logic [DATA_W-1:0] i_data_EX,
  input  logic [RD_W-1:0]   i_rd_addr_EX,
  input  logic [CTRL_W-1:0] i_ctrl_EX,
  input  logic              i_flush,
  output logic              o_valid_M,
  input  logic              i_ready_M,
  output logic [DATA_W-1:0] o_data_M,
  output logic [RD_W-1:0]   o_rd_addr_M,
  output logic [CTRL_W-1:0] o_ctrl_M,
  output logic              o_fwd_rdwren,
  output logic [RD_W-1:0]   o_fwd_rd_addr,
  output logic [CNT_W-1:0]  o_stall_cnt
);

`ifdef EX_M_SKID_EN
  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;
`else
  typedef enum logic {S_EMPTY, S_FULL} state_t;
`endif

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic [RD_W-1:0]   r_rd;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_valid;
  logic w_xfer_in;
  logic w_xfer_out;
  logic w_stall;

  assign w_valid    = (r_state != S_EMPTY);
  assign w_xfer_in  = i_valid_EX & o_ready_EX;
  assign w_xfer_out = w_valid & i_ready_M;
  assign w_stall    = w_valid & ~i_ready_M & ~i_flush;

`ifdef EX_M_SKID_EN
  logic [DATA_W-1:0] r_skid_data;
  logic [RD_W-1:0]   r_skid_rd;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              r_ready_EX;
  logic              w_skid_load;

  assign w_skid_load = (r_state == S_FULL) & w_xfer_in & ~w_xfer_out;
  assign o_ready_EX  = ~i_flush & r_ready_EX;

  // r_ready_EX is the registered "skid not occupied" term; held low through reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_skid_data <= '0;
      r_skid_rd   <= '0;
      r_skid_ctrl <= '0;
      r_ready_EX  <= 1'b0;
    end else begin
      if (w_skid_load) begin
        r_skid_data <= i_data_EX;
        r_skid_rd   <= i_rd_addr_EX;
        r_skid_ctrl <= i_ctrl_EX;
      end
      if (i_flush) begin
        r_ready_EX <= 1'b1;
      end else begin
        r_ready_EX <= ~(w_skid_load | ((r_state == S_SKID) & ~w_xfer_out));
      end
    end
  end
`else
  assign o_ready_EX = ~i_flush & (~w_valid | i_ready_M);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_EMPTY;
      r_data  <= '0;
      r_rd    <= '0;
      r_ctrl  <= '0;
    end else if (i_flush) begin
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_xfer_in) begin
            r_state <= S_FULL;
            r_data  <= i_data_EX;
            r_rd    <= i_rd_addr_EX;
            r_ctrl  <= i_ctrl_EX;
          end
        end
        S_FULL: begin
          if (w_xfer_in && w_xfer_out) begin
            r_data <= i_data_EX;
            r_rd   <= i_rd_addr_EX;
            r_ctrl <= i_ctrl_EX;
          end else if (w_xfer_out) begin
            r_state <= S_EMPTY;
`ifdef EX_M_SKID_EN
          end else if (w_xfer_in) begin
            r_state <= S_SKID;
`endif
          end
        end
`ifdef EX_M_SKID_EN
        S_SKID: begin
          if (w_xfer_out) begin
            r_state <= S_FULL;
            r_data  <= r_skid_data;
            r_rd    <= r_skid_rd;
            r_ctrl  <= r_skid_ctrl;
          end
        end
`endif
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Control is masked while invalid so a bubble can never write RF or memory.
  assign o_valid_M     = w_valid;
  assign o_data_M      = r_data;
  assign o_rd_addr_M   = r_rd;
  assign o_ctrl_M      = w_valid ? r_ctrl : '0;
  assign o_fwd_rdwren  = w_valid & r_ctrl[RDWREN_BIT];
  assign o_fwd_rd_addr = r_rd;
  assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: queue-based reference model (capacity 1, or 2 with EX_M_SKID_EN).
module tb_ex_mem_pipe_reg;
  localparam int DW = 128;
  localparam int RW = 5;
  localparam int CW = 6;
  localparam int NW = 4;
  localparam logic [NW-1:0] CNT_MAX = 4'd15;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_valid_EX;
  logic          o_ready_EX;
  logic [DW-1:0] i_data_EX;
  logic [RW-1:0] i_rd_addr_EX;
  logic [CW-1:0] i_ctrl_EX;
  logic          i_flush;
  logic          o_valid_M;
  logic          i_ready_M;
  logic [DW-1:0] o_data_M;
  logic [RW-1:0] o_rd_addr_M;
  logic [CW-1:0] o_ctrl_M;
  logic          o_fwd_rdwren;
  logic [RW-1:0] o_fwd_rd_addr;
  logic [NW-1:0] o_stall_cnt;

  ex_mem_pipe_reg #(.DATA_W(DW), .RD_W(RW), .CTRL_W(CW), .RDWREN_BIT(0), .CNT_W(NW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid_EX(i_valid_EX), .o_ready_EX(o_ready_EX),
    .i_data_EX(i_data_EX), .i_rd_addr_EX(i_rd_addr_EX), .i_ctrl_EX(i_ctrl_EX),
    .i_flush(i_flush), .o_valid_M(o_valid_M), .i_ready_M(i_ready_M), .o_data_M(o_data_M),
    .o_rd_addr_M(o_rd_addr_M), .o_ctrl_M(o_ctrl_M), .o_fwd_rdwren(o_fwd_rdwren),
    .o_fwd_rd_addr(o_fwd_rd_addr), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [RW-1:0] rd;
    logic [CW-1:0] c;
  } item_t;

  item_t q[$];
  item_t pend;
  int    checks = 0;
  int    errors = 0;
  bit    rdy_exp;
  bit    acc;
  bit    inc;
  bit    post_rst;
  bit    flush_now;
  bit    done = 1'b0;
  int    cnt_exp;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
`ifdef EX_M_SKID_EN
    return !i_flush && !post_rst && (q.size() < 2);
`else
    return !i_flush && ((q.size() == 0) || i_ready_M);
`endif
  endfunction

  // One clock: commit the model for the edge, then drive the next cycle's inputs.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input logic [RW-1:0] rd,
                       input logic [CW-1:0] c, input bit fl, input bit rm);
    @(posedge i_clk);
    if (flush_now) q.delete();
    else if (acc) q.push_back(pend);
    if (inc && cnt_exp < int'(CNT_MAX)) cnt_exp++;
    post_rst = 1'b0;
    #1;
    i_valid_EX = v; i_data_EX = d; i_rd_addr_EX = rd; i_ctrl_EX = c;
    i_flush = fl; i_ready_M = rm;
    rdy_exp   = model_ready();
    acc       = v && rdy_exp;
    pend      = '{d: d, rd: rd, c: c};
    flush_now = fl;
    inc       = !fl && (q.size() > 0) && !rm;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [RW-1:0] rd,
                      input logic [CW-1:0] c, input bit rm);
    int n = 0;
    do begin
      cycle(1'b1, d, rd, c, 1'b0, rm);
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input bit rm);
    cycle(1'b0, '0, '0, '0, 1'b0, rm);
  endtask

  task automatic set_idle_inputs();
    i_valid_EX = 1'b0; i_data_EX = '0; i_rd_addr_EX = '0; i_ctrl_EX = '0;
    i_flush = 1'b0; i_ready_M = 1'b0;
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_valid"}, o_valid_M, 0);
    chk({tag, "_data"}, o_data_M, 0);
    chk({tag, "_rd"}, o_rd_addr_M, 0);
    chk({tag, "_ctrl"}, o_ctrl_M, 0);
    chk({tag, "_fwd_we"}, o_fwd_rdwren, 0);
    chk({tag, "_fwd_rd"}, o_fwd_rd_addr, 0);
    chk({tag, "_cnt"}, o_stall_cnt, 0);
`ifdef EX_M_SKID_EN
    chk({tag, "_ready"}, o_ready_EX, 0);
`else
    chk({tag, "_ready"}, o_ready_EX, 1);
`endif
  endtask

  // Release reset mid-cycle; the model restarts empty.
  task automatic release_reset();
    @(posedge i_clk);
    #3;
    i_rst_n   = 1'b1;
    post_rst  = 1'b1;
    q.delete();
    cnt_exp   = 0;
    rdy_exp   = model_ready();
    acc       = 1'b0;
    inc       = 1'b0;
    flush_now = 1'b0;
  endtask

  // Monitor: compare M-side outputs against the head of the expected queue.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n && !done) begin
        chk("ready_EX", o_ready_EX, rdy_exp);
        chk("valid_M", o_valid_M, q.size() > 0);
        chk("stall_cnt", o_stall_cnt, cnt_exp);
        if (q.size() > 0) begin
          chk("data_M", o_data_M, q[0].d);
          chk("rd_M", o_rd_addr_M, q[0].rd);
          chk("ctrl_M", o_ctrl_M, q[0].c);
          chk("fwd_rdwren", o_fwd_rdwren, q[0].c[0]);
          chk("fwd_rd", o_fwd_rd_addr, q[0].rd);
          if (i_ready_M) void'(q.pop_front());
        end else begin
          chk("ctrl_bubble", o_ctrl_M, 0);
          chk("fwd_bubble", o_fwd_rdwren, 0);
        end
      end
    end
  end

  initial begin
    i_rst_n = 1'b0;
    set_idle_inputs();
    cnt_exp = 0; post_rst = 1'b0; flush_now = 1'b0; acc = 1'b0; inc = 1'b0; rdy_exp = 1'b0;
    #2;
    check_reset_zero("rst");
    release_reset();

    // stream 1..4 back-to-back
    for (int unsigned k = 1; k <= 4; k++) send(DW'(k), RW'(k), 6'd0, 1'b1);
    repeat (3) idle(1'b1);

    // back-pressure: 0xA held for 5 stall edges, 0xB offered meanwhile
    send(DW'(32'hA), 5'd10, 6'd0, 1'b0);
    repeat (5) cycle(1'b1, DW'(32'hB), 5'd11, 6'd0, 1'b0, 1'b0);
    cycle(1'b1, DW'(32'hB), 5'd11, 6'd0, 1'b0, 1'b1);
    chk("bp_cnt5", o_stall_cnt, 5);
    chk("bp_hold", o_data_M, DW'(32'hA));
    repeat (4) idle(1'b1);

    // flush with rdwren=1, rd=7 held (plus skid entry when compiled in)
    send(DW'(32'h77), 5'd7, 6'd1, 1'b0);
    cycle(1'b1, DW'(32'h78), 5'd8, 6'd1, 1'b0, 1'b0);
    cycle(1'b1, DW'(32'hDEAD), 5'd9, 6'd1, 1'b1, 1'b0);
    idle(1'b1);
    chk("flush_valid", o_valid_M, 0);
    chk("flush_ctrl", o_ctrl_M, 0);
    chk("flush_fwd", o_fwd_rdwren, 0);
    repeat (3) idle(1'b1);

    // async reset mid-stall
    send(DW'(32'h55), 5'd5, 6'd1, 1'b0);
    repeat (3) idle(1'b0);
    #2;
    i_rst_n = 1'b0;
    set_idle_inputs();
    #1;
    check_reset_zero("rst_mid");
    release_reset();

    // saturation: 20 stall cycles on a 4-bit counter
    send(DW'(32'h99), 5'd3, 6'd0, 1'b0);
    repeat (20) idle(1'b0);
    idle(1'b1);
    chk("sat_cnt", o_stall_cnt, CNT_MAX);
    repeat (3) idle(1'b1);

    // bubbles carrying all-ones control
    repeat (4) cycle(1'b0, '1, '1, '1, 1'b0, 1'($urandom_range(0, 1)));

    // random traffic
    for (int unsigned k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            {$urandom, $urandom, $urandom, $urandom},
            RW'($urandom), CW'($urandom),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < 7));
    end
    repeat (5) idle(1'b1);
    @(posedge i_clk);
    #1;
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
